magnitude_compare_seq: RTL and testbench
========================================

# magnitude_compare_seq

Parametrised, multi-cycle magnitude comparator. It compares two WIDTH-bit operands DIGIT bits per cycle, most-significant slice first, and stops at the first slice that differs. It supports unsigned and two's-complement modes and uses a start/done handshake. It replaces the fixed 2-bit combinational comparator wherever wide operands would make a single-cycle compare too deep for timing.

## Interface
- WIDTH, default 8: operand width in bits. Must be ≥ 2.
- DIGIT, default 2: bits examined per cycle. WIDTH % DIGIT must be 0, otherwise elaboration fails with $error.
- SIGNED, default 0: 0 compares unsigned; 1 compares two's-complement.
- Derived: N = WIDTH/DIGIT slices; the slice counter is $clog2(N+1) bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a compare; sampled only when busy=0
- x  input  WIDTH  operand A; sampled on the accepting edge only
- y  input  WIDTH  operand B; sampled on the accepting edge only
- busy  output  1  high while in COMPARE
- done  output  1  one-cycle pulse marking a new result
- g  output  1  x > y
- l  output  1  x < y
- e  output  1  x == y

## Operation
- Reset (asynchronous, immediate): state=IDLE; busy=0, done=0, g=0, l=0, e=0. Shift registers and the slice counter are cleared.
- IDLE state:
  - start=1 on an edge: load sx←x and sy←y, set cnt←N, go to COMPARE.
  - When SIGNED=1, invert bit WIDTH-1 of both operands on load (offset-binary trick). The datapath after load is always unsigned.
- COMPARE state: each edge examines the top slice a=sx[WIDTH-1 -: DIGIT], b=sy[WIDTH-1 -: DIGIT].
  - a>b: g=1, l=0, e=0; done=1; go to IDLE.
  - a<b: g=0, l=1, e=0; done=1; go to IDLE.
  - a==b and cnt==1: g=0, l=0, e=1; done=1; go to IDLE.
  - a==b and cnt>1: shift sx and sy left by DIGIT; cnt←cnt-1; stay in COMPARE.
- start while busy=1 is ignored. No queueing and no error flag.
- g/l/e are registered. They hold their value from one done pulse until the next done pulse, including throughout a subsequent COMPARE.
- After the first completion, exactly one of g/l/e is 1. Before the first completion, all three are 0.
- done is registered and is high for exactly one cycle per accepted start.

## Timing
- Accepting edge E0 (start=1, busy=0): busy=1 from E0.
- Let k be the index of the first differing slice (1 = MSB slice), or k=N if the operands are equal.
- Result edge Ek: g/l/e update, done=1 and busy=0 in the same cycle. Latency is k cycles, with 1 ≤ k ≤ N.
- done falls at Ek+1 unless a new result is produced at that edge.
- Back-to-back operation: start=1 during the done cycle is accepted at Ek+1, because busy is already 0. Peak throughput is one compare per k+1 cycles.
- rst asserted mid-COMPARE aborts the compare immediately. The in-flight request is lost and all outputs return to their reset values.
- If start is high on the first edge after rst deasserts, the request is accepted normally.
- x/y may change freely while busy=1 without affecting the result.

## Test plan
- WIDTH=8, DIGIT=2, SIGNED=0; x=8'hC3, y=8'h43, start for 1 cycle -> at E1: done=1, g=1, l=0, e=0, busy=0 (MSB slice 11 vs 01).
- Same config; x=8'h5A, y=8'h5B -> busy for 4 cycles; at E4: done=1, l=1, g=0, e=0.
- Same config; x=y=8'hA5 -> at E4: done=1, e=1. Then drive start=1 with x=8'h00, y=8'h01 during the done cycle -> accepted at E5; result l=1 at E9, with e=1 held until then.
- SIGNED=1, WIDTH=8, DIGIT=2; x=8'hFF (-1), y=8'h01 -> at E1: l=1. Then x=8'h80 (-128), y=8'h80 -> at E4: e=1.
- Same config as the first scenario; x=8'h5A, y=8'h5B, then pulse start again at E2 with x=8'hFF -> second start ignored; result at E4 is l=1 with a single done pulse.
- Start the compare of the second scenario, then assert rst between E1 and E2 -> busy=0, done=0, g=l=e=0 immediately (asynchronous) and no done pulse afterwards. Re-run the second scenario after reset -> the result is again l=1 at E4.

Source files
------------

// File: rtl/magnitude_compare_seq_if.sv
// Start/done handshake bundle for the sequential magnitude comparator.
// The requester drives start/x/y; the comparator returns busy/done and the g/l/e flags.
interface magnitude_compare_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic             g;
    logic             l;
    logic             e;

    modport master (output start, x, y, input busy, done, g, l, e);
    modport slave  (input start, x, y, output busy, done, g, l, e);
endinterface

// File: rtl/magnitude_compare_seq.sv
// Multi-cycle magnitude comparator: walks DIGIT-bit slices from the MSB down and
// stops at the first slice that differs, so a wide compare never needs a deep carry chain.
module magnitude_compare_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGIT  = 2,
    parameter bit SIGNED = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    magnitude_compare_seq_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    localparam logic [WIDTH-1:0] LOAD_FLIP = SIGNED ? (WIDTH'(1) << (WIDTH - 1)) : '0;

    if (WIDTH < 2) begin : g_width_chk
        $error("magnitude_compare_seq: WIDTH must be >= 2");
    end
    if (WIDTH % DIGIT != 0) begin : g_digit_chk
        $error("magnitude_compare_seq: WIDTH must be a multiple of DIGIT");
    end

    typedef enum logic {
        IDLE,
        COMPARE
    } state_t;

    state_t            state, state_d;
    logic [WIDTH-1:0]  sx, sx_d;
    logic [WIDTH-1:0]  sy, sy_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic              g_q, g_d;
    logic              l_q, l_d;
    logic              e_q, e_d;
    logic              done_q, done_d;
    logic [DIGIT-1:0]  a, b;

    assign a = sx[WIDTH-1 -: DIGIT];
    assign b = sy[WIDTH-1 -: DIGIT];

    // NOTE: every signal gets its default first, so no path through the case leaves a latch.
    always_comb begin
        state_d = state;
        sx_d    = sx;
        sy_d    = sy;
        cnt_d   = cnt;
        g_d     = g_q;
        l_d     = l_q;
        e_d     = e_q;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    sx_d    = bus.x ^ LOAD_FLIP;
                    sy_d    = bus.y ^ LOAD_FLIP;
                    cnt_d   = CW'(N);
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (a > b) begin
                    {g_d, l_d, e_d} = 3'b100;
                    done_d          = 1'b1;
                    state_d         = IDLE;
                end else if (a < b) begin
                    {g_d, l_d, e_d} = 3'b010;
                    done_d          = 1'b1;
                    state_d         = IDLE;
                end else if (cnt == CW'(1)) begin
                    {g_d, l_d, e_d} = 3'b001;
                    done_d          = 1'b1;
                    state_d         = IDLE;
                end else begin
                    sx_d  = sx << DIGIT;
                    sy_d  = sy << DIGIT;
                    cnt_d = cnt - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sx     <= '0;
            sy     <= '0;
            cnt    <= '0;
            g_q    <= 1'b0;
            l_q    <= 1'b0;
            e_q    <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_d;
            sx     <= sx_d;
            sy     <= sy_d;
            cnt    <= cnt_d;
            g_q    <= g_d;
            l_q    <= l_d;
            e_q    <= e_d;
            done_q <= done_d;
        end
    end

    assign bus.busy = (state == COMPARE);
    assign bus.done = done_q;
    assign bus.g    = g_q;
    assign bus.l    = l_q;
    assign bus.e    = e_q;
endmodule

// File: tb/tb_magnitude_compare_seq.sv
// Bench for magnitude_compare_seq: an unsigned and a signed instance (WIDTH=8, DIGIT=2),
// expected flags and latencies queued at issue time and compared when done appears.
module tb_magnitude_compare_seq;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    magnitude_compare_seq_if #(.WIDTH(8)) u_if ();
    magnitude_compare_seq_if #(.WIDTH(8)) s_if ();

    magnitude_compare_seq #(.WIDTH(8), .DIGIT(2), .SIGNED(1'b0)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );
    magnitude_compare_seq #(.WIDTH(8), .DIGIT(2), .SIGNED(1'b1)) s_dut (
        .clk (clk),
        .rst (rst),
        .bus (s_if)
    );

    typedef struct {
        logic [2:0] gle;
        int         k;
    } exp_t;

    exp_t sb[$];

    // Reference: plain relational compare for the flags, slice scan for the latency.
    function automatic exp_t model(input bit sgn, input logic [7:0] a, input logic [7:0] b);
        exp_t r;
        if (sgn) r.gle = {$signed(a) > $signed(b), $signed(a) < $signed(b), a == b};
        else     r.gle = {a > b, a < b, a == b};
        r.k = 4;
        for (int i = 0; i < 4; i++) begin
            if (a[7-2*i -: 2] != b[7-2*i -: 2]) begin
                r.k = i + 1;
                break;
            end
        end
        return r;
    endfunction

    function automatic logic [2:0] obs_gle(input bit sgn);
        return sgn ? {s_if.g, s_if.l, s_if.e} : {u_if.g, u_if.l, u_if.e};
    endfunction

    function automatic logic obs_done(input bit sgn);
        return sgn ? s_if.done : u_if.done;
    endfunction

    function automatic logic obs_busy(input bit sgn);
        return sgn ? s_if.busy : u_if.busy;
    endfunction

    function automatic logic [4:0] obs_all(input bit sgn);
        return {obs_busy(sgn), obs_done(sgn), obs_gle(sgn)};
    endfunction

    task automatic drive(input bit sgn, input logic st, input logic [7:0] a, input logic [7:0] b);
        if (sgn) begin
            s_if.start = st; s_if.x = a; s_if.y = b;
        end else begin
            u_if.start = st; u_if.x = a; u_if.y = b;
        end
    endtask

    task automatic issue(input bit sgn, input logic [7:0] a, input logic [7:0] b);
        drive(sgn, 1'b1, a, b);
        sb.push_back(model(sgn, a, b));
    endtask

    // Called at the negedge where start was raised; returns at the negedge showing done.
    // Operands are scrambled while busy; steady drops if busy falls or g/l/e move early.
    task automatic wait_result(input bit sgn, output logic busy0, output int k,
                               output bit timeout, output bit steady);
        logic [2:0] prev;
        @(negedge clk);
        drive(sgn, 1'b0, 8'($urandom), 8'($urandom));
        busy0   = obs_busy(sgn);
        prev    = obs_gle(sgn);
        steady  = 1'b1;
        timeout = 1'b1;
        k       = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (obs_done(sgn)) begin
                k       = c;
                timeout = 1'b0;
                break;
            end
            if (obs_gle(sgn) !== prev || obs_busy(sgn) !== 1'b1) steady = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        n_checks++; if (obs_all(1'b0) !== 5'b0) $display("FAIL reset_unsigned: got %b want 00000", obs_all(1'b0)); else n_pass++;
        n_checks++; if (obs_all(1'b1) !== 5'b0) $display("FAIL reset_signed: got %b want 00000", obs_all(1'b1)); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (obs_all(1'b0) !== 5'b0) $display("FAIL idle_after_reset: got %b want 00000", obs_all(1'b0)); else n_pass++;
    endtask

    task automatic test_msb_greater();
        exp_t ex; logic b0; int k; bit to, st;
        issue(1'b0, 8'hC3, 8'h43);
        wait_result(1'b0, b0, k, to, st);
        ex = sb.pop_front();
        n_checks++; if (b0 !== 1'b1) $display("FAIL msb_gt_busy_e0: got %b want 1", b0); else n_pass++;
        n_checks++; if (to || k != ex.k) $display("FAIL msb_gt_latency: got %0d want %0d", k, ex.k); else n_pass++;
        n_checks++; if (obs_gle(1'b0) !== ex.gle) $display("FAIL msb_gt_gle: got %b want %b", obs_gle(1'b0), ex.gle); else n_pass++;
        n_checks++; if (obs_busy(1'b0) !== 1'b0) $display("FAIL msb_gt_busy_done: got %b want 0", obs_busy(1'b0)); else n_pass++;
        @(negedge clk);
        n_checks++; if (obs_done(1'b0) !== 1'b0) $display("FAIL msb_gt_done_fall: got %b want 0", obs_done(1'b0)); else n_pass++;
        n_checks++; if (obs_gle(1'b0) !== ex.gle) $display("FAIL msb_gt_hold: got %b want %b", obs_gle(1'b0), ex.gle); else n_pass++;
    endtask

    task automatic test_lsb_less();
        exp_t ex; logic b0; int k; bit to, st;
        issue(1'b0, 8'h5A, 8'h5B);
        wait_result(1'b0, b0, k, to, st);
        ex = sb.pop_front();
        n_checks++; if (to || k != ex.k) $display("FAIL lsb_lt_latency: got %0d want %0d", k, ex.k); else n_pass++;
        n_checks++; if (!st) $display("FAIL lsb_lt_busy_hold: busy or flags moved before done"); else n_pass++;
        n_checks++; if (obs_gle(1'b0) !== ex.gle) $display("FAIL lsb_lt_gle: got %b want %b", obs_gle(1'b0), ex.gle); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        exp_t ex; logic b0; int k; bit to, st;
        issue(1'b0, 8'hA5, 8'hA5);
        wait_result(1'b0, b0, k, to, st);
        ex = sb.pop_front();
        n_checks++; if (to || k != ex.k) $display("FAIL b2b_eq_latency: got %0d want %0d", k, ex.k); else n_pass++;
        n_checks++; if (obs_gle(1'b0) !== ex.gle) $display("FAIL b2b_eq_gle: got %b want %b", obs_gle(1'b0), ex.gle); else n_pass++;
        issue(1'b0, 8'h00, 8'h01);
        wait_result(1'b0, b0, k, to, st);
        n_checks++; if (b0 !== 1'b1) $display("FAIL b2b_accept: busy got %b want 1", b0); else n_pass++;
        n_checks++; if (!st) $display("FAIL b2b_e_held: e not held through second compare"); else n_pass++;
        ex = sb.pop_front();
        n_checks++; if (to || k != ex.k) $display("FAIL b2b_lt_latency: got %0d want %0d", k, ex.k); else n_pass++;
        n_checks++; if (obs_gle(1'b0) !== ex.gle) $display("FAIL b2b_lt_gle: got %b want %b", obs_gle(1'b0), ex.gle); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_signed();
        exp_t ex; logic b0; int k; bit to, st;
        logic [7:0] pairs [4] = '{8'hFF, 8'h01, 8'h80, 8'h80};
        logic [7:0] more  [2] = '{8'h7F, 8'h80};
        for (int i = 0; i < 3; i++) begin
            if (i < 2) issue(1'b1, pairs[2*i], pairs[2*i+1]);
            else       issue(1'b1, more[0], more[1]);
            wait_result(1'b1, b0, k, to, st);
            ex = sb.pop_front();
            n_checks++; if (to || k != ex.k) $display("FAIL signed_%0d_latency: got %0d want %0d", i, k, ex.k); else n_pass++;
            n_checks++; if (obs_gle(1'b1) !== ex.gle) $display("FAIL signed_%0d_gle: got %b want %b", i, obs_gle(1'b1), ex.gle); else n_pass++;
            @(negedge clk);
        end
        issue(1'b0, 8'hFF, 8'h01);
        wait_result(1'b0, b0, k, to, st);
        ex = sb.pop_front();
        n_checks++; if (obs_gle(1'b0) !== ex.gle) $display("FAIL unsigned_ff_gle: got %b want %b", obs_gle(1'b0), ex.gle); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_busy_ignored();
        exp_t ex; int n_done = 0; int first = 0; logic [2:0] got = 3'b000;
        issue(1'b0, 8'h5A, 8'h5B);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h5A, 8'h5B);
        @(negedge clk);
        drive(1'b0, 1'b1, 8'hFF, 8'h5B);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        for (int n = 3; n <= 12; n++) begin
            @(negedge clk);
            if (obs_done(1'b0)) begin
                n_done++;
                if (first == 0) begin first = n; got = obs_gle(1'b0); end
            end
        end
        ex = sb.pop_front();
        n_checks++; if (n_done != 1) $display("FAIL ignored_done_count: got %0d want 1", n_done); else n_pass++;
        n_checks++; if (first != ex.k) $display("FAIL ignored_latency: got %0d want %0d", first, ex.k); else n_pass++;
        n_checks++; if (got !== ex.gle) $display("FAIL ignored_gle: got %b want %b", got, ex.gle); else n_pass++;
    endtask

    task automatic test_reset_abort();
        exp_t ex; logic b0; int k; bit to, st; int n_done = 0;
        issue(1'b0, 8'h5A, 8'h5B);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h5A, 8'h5B);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        void'(sb.pop_front());
        n_checks++; if (obs_all(1'b0) !== 5'b0) $display("FAIL abort_async: got %b want 00000", obs_all(1'b0)); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (obs_done(1'b0)) n_done++;
        end
        n_checks++; if (n_done != 0) $display("FAIL abort_no_done: got %0d pulses want 0", n_done); else n_pass++;
        n_checks++; if (obs_all(1'b0) !== 5'b0) $display("FAIL abort_idle: got %b want 00000", obs_all(1'b0)); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        issue(1'b0, 8'h5A, 8'h5B);
        wait_result(1'b0, b0, k, to, st);
        ex = sb.pop_front();
        n_checks++; if (b0 !== 1'b1) $display("FAIL rerun_accept: busy got %b want 1", b0); else n_pass++;
        n_checks++; if (to || k != ex.k) $display("FAIL rerun_latency: got %0d want %0d", k, ex.k); else n_pass++;
        n_checks++; if (obs_gle(1'b0) !== ex.gle) $display("FAIL rerun_gle: got %b want %b", obs_gle(1'b0), ex.gle); else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_msb_greater();
        test_lsb_less();
        test_back_to_back();
        test_signed();
        test_busy_ignored();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
